cga_mac_segpt_ptw: RTL

- Page-table walk sequencer, directly downstream of the segment register in MAC/SEGPT.
- Consumes SEG_7_0/SEGZN plus a virtual page request.
- Fetches the 16-bit page-table entry (PTE) over a simple memory handshake, checks access rights, and writes PGU/WIP back when needed.
- Returns a 9-bit physical page number (PPN) or a fault code.

---
 rtl/cga_mac_segpt_pkg.sv | 36 +++
 rtl/cga_mac_segpt_ptw_chk.sv | 27 ++
 rtl/cga_mac_segpt_ptw.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cga_mac_segpt_pkg.sv
// Shared types and constants for the MAC/SEGPT page-table walk sequencer.
package cga_mac_segpt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CHK   = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // PTE bit positions
  localparam int PTE_WPM     = 15;
  localparam int PTE_RPM     = 14;
  localparam int PTE_FPM     = 13;
  localparam int PTE_WIP     = 12;
  localparam int PTE_PGU     = 11;
  localparam int PTE_RING_HI = 10;
  localparam int PTE_RING_LO = 9;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_PERM = 2'b01;
  localparam logic [1:0] FC_RING = 2'b10;
  localparam logic [1:0] FC_TMO  = 2'b11;

  // PTE as written back: page always marked used, write-in-progress only for writes.
  function automatic logic [15:0] wb_pte(input logic [15:0] pte, input logic wr);
    logic [15:0] r;
    r = pte;
    r[PTE_PGU] = 1'b1;
    if (wr) r[PTE_WIP] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cga_mac_segpt_ptw_chk.sv
// Combinational PTE access check: permission fault beats ring fault; also
// reports whether the PTE status bits need a write-back.
module cga_mac_segpt_ptw_chk
  import cga_mac_segpt_pkg::*;
(
  input  logic [15:0] pte,
  input  logic [2:0]  acc,
  input  logic [1:0]  ring,
  output logic        fault,
  output logic [1:0]  fcode,
  output logic        wb_need
);

  logic perm_bad;
  logic ring_bad;

  always_comb begin
    perm_bad = (acc[2] & ~pte[PTE_WPM]) |
               (acc[1] & ~pte[PTE_RPM]) |
               (acc[0] & ~pte[PTE_FPM]);
    ring_bad = ring < pte[PTE_RING_HI:PTE_RING_LO];
    fault    = perm_bad | ring_bad;
    fcode    = perm_bad ? FC_PERM : (ring_bad ? FC_RING : FC_NONE);
    wb_need  = ~pte[PTE_PGU] | (acc[2] & ~pte[PTE_WIP]);
  end

endmodule

// File: rtl/cga_mac_segpt_ptw.sv
// Page-table walk sequencer: fetch PTE, check rights, write back PGU/WIP, return PPN.
// Optional one-entry translation cache: define CGA_MAC_SEGPT_PTW_HIT_CACHE_EN.
module cga_mac_segpt_ptw
  import cga_mac_segpt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int PPN_W          = 9
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic [7:0]       SEG_7_0,
  input  logic             SEGZN,
  input  logic             REQ,
  input  logic [5:0]       VPN_5_0,
  input  logic [2:0]       ACC_2_0,
  input  logic [1:0]       RING_1_0,
  output logic             MREQ,
  output logic             MWE,
  output logic [13:0]      MADR_13_0,
  input  logic [15:0]      MDI_15_0,
  output logic [15:0]      MDO_15_0,
  input  logic             MACK,
  output logic             ACK,
  output logic             FAULT,
  output logic [1:0]       FCODE_1_0,
  output logic [PPN_W-1:0] PPN,
  output logic             BUSY,
  output state_e           dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q;
  logic [7:0]       seg_q;
  logic [5:0]       vpn_q;
  logic [2:0]       acc_q;
  logic [1:0]       ring_q;
  logic [15:0]      pte_q;
  logic [PPN_W-1:0] ppn_q;
  logic [1:0]       fcode_q;
  logic             chk_fault, chk_wb;
  logic [1:0]       chk_fcode;
  logic [15:0]      wb_data;
  logic             tmo;
  logic             cache_hit;

  cga_mac_segpt_ptw_chk u_chk (
    .pte     (pte_q),
    .acc     (acc_q),
    .ring    (ring_q),
    .fault   (chk_fault),
    .fcode   (chk_fcode),
    .wb_need (chk_wb)
  );

  assign wb_data = wb_pte(pte_q, acc_q[2]);
  assign tmo     = (cnt_q == TMO_LAST);

`ifdef CGA_MAC_SEGPT_PTW_HIT_CACHE_EN
  logic        cv_q, walked_q;
  logic [7:0]  cseg_q;
  logic [5:0]  cvpn_q;
  logic [15:0] cpte_q;

  assign cache_hit = cv_q && (cseg_q == SEG_7_0) && (cvpn_q == VPN_5_0);

  // Only walks that fetched from memory refill; a SEG change drops the entry at once.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      cv_q     <= 1'b0;
      walked_q <= 1'b0;
      cseg_q   <= '0;
      cvpn_q   <= '0;
      cpte_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && REQ) walked_q <= 1'b0;
      if (state_q == ST_RD)          walked_q <= 1'b1;
      if (state_q == ST_DONE && walked_q) begin
        cv_q   <= 1'b1;
        cseg_q <= seg_q;
        cvpn_q <= vpn_q;
        cpte_q <= pte_q;
      end else if (state_d == ST_FAULT || (cv_q && SEG_7_0 != cseg_q)) begin
        cv_q <= 1'b0;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge MCLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (REQ) begin
                  if (!SEGZN)         state_d = ST_DONE;
                  else if (cache_hit) state_d = ST_CHK;
                  else                state_d = ST_RD;
                end
      ST_RD:    if (MACK)     state_d = ST_CHK;
                else if (tmo) state_d = ST_FAULT;
      ST_CHK:   if (chk_fault)   state_d = ST_FAULT;
                else if (chk_wb) state_d = ST_WB;
                else             state_d = ST_DONE;
      ST_WB:    if (MACK)     state_d = ST_DONE;
                else if (tmo) state_d = ST_FAULT;
      ST_DONE,
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      seg_q   <= '0;
      vpn_q   <= '0;
      acc_q   <= '0;
      ring_q  <= '0;
      pte_q   <= '0;
      ppn_q   <= '0;
      fcode_q <= '0;
    end else begin
      if (state_q == ST_IDLE && REQ) begin
        seg_q  <= SEG_7_0;
        vpn_q  <= VPN_5_0;
        acc_q  <= ACC_2_0;
        ring_q <= RING_1_0;
        if (!SEGZN) ppn_q <= PPN_W'(VPN_5_0);
`ifdef CGA_MAC_SEGPT_PTW_HIT_CACHE_EN
        if (SEGZN && cache_hit) pte_q <= cpte_q;
`endif
      end
      if (state_q == ST_RD && MACK) pte_q <= MDI_15_0;
      // Keep the PTE as written so a later cache fill stores the updated bits.
      if (state_q == ST_WB && MACK) pte_q <= wb_data;
      if (state_d == ST_DONE && state_q != ST_IDLE) ppn_q <= pte_q[PPN_W-1:0];
      if (state_d == ST_FAULT) fcode_q <= (state_q == ST_CHK) ? chk_fcode : FC_TMO;
      if ((state_d == ST_RD && state_q != ST_RD) || (state_d == ST_WB && state_q != ST_WB))
        cnt_q <= '0;
      else if (state_q == ST_RD || state_q == ST_WB)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  // Memory handshake: MREQ holds with stable MADR/MWE/MDO until a one-cycle MACK
  // completes the cycle; a sampled RESET drops MREQ in the same cycle.
  always_comb begin
    MREQ     = 1'b0;
    MWE      = 1'b0;
    MDO_15_0 = '0;
    ACK      = 1'b0;
    FAULT    = 1'b0;
    unique case (state_q)
      ST_RD:    MREQ = ~RESET;
      ST_WB:    begin
                  MREQ     = ~RESET;
                  MWE      = ~RESET;
                  MDO_15_0 = wb_data;
                end
      ST_DONE:  ACK = 1'b1;
      ST_FAULT: begin
                  ACK   = 1'b1;
                  FAULT = 1'b1;
                end
      default:  ;
    endcase
  end

  assign MADR_13_0 = {seg_q, vpn_q};
  assign FCODE_1_0 = fcode_q;
  assign PPN       = ppn_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
